// File: rtl/touch_scan_sequencer.sv
// Scan sequencer for a 4-wire resistive touch panel: settles each electrode set-up,
// requests ADC conversions over a req/ack handshake, averages X/Y and reports a coordinate.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | drives off, waiting for ENABLE
// PEN_SETTLE   | pen-detect configuration applied, waiting to settle
// PEN_SAMPLE   | one pen-detect conversion
// X_SETTLE     | X-measure configuration applied, waiting to settle
// X_SAMPLE     | collecting the X samples
// Y_SETTLE     | Y-measure configuration applied, waiting to settle
// Y_SAMPLE     | collecting the Y samples
// CHK_SETTLE   | pen-detect configuration re-applied after the axes
// CHK_SAMPLE   | confirm the pen is still down before reporting
// REPORT       | coordinate outputs updated, XY_VALID high
module touch_scan_sequencer #(
    parameter int unsigned      ADC_W         = 12,
    parameter int unsigned      AVG_LOG2      = 2,
    parameter int unsigned      SETTLE_CYCLES = 1000,
    parameter logic [ADC_W-1:0] PEN_THRESH    = ADC_W'('h100)
) (
    input  logic             FAB_CLK,
    input  logic             FAB_RST,
    input  logic             ENABLE,
    output logic [3:0]       DRIVE_EN,
    output logic [3:0]       DRIVE_VAL,
    output logic             SAMPLE_REQ,
    output logic             SAMPLE_CH,
    input  logic             SAMPLE_ACK,
    input  logic [ADC_W-1:0] SAMPLE_DATA,
    output logic [ADC_W-1:0] X_OUT,
    output logic [ADC_W-1:0] Y_OUT,
    output logic             XY_VALID,
    output logic             PEN_DOWN
);

    localparam int unsigned ACC_W  = ADC_W + AVG_LOG2;
    localparam int unsigned SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SCNT_W-1:0] LAST_SMP    = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PEN_SETTLE,
        S_PEN_SAMPLE,
        S_X_SETTLE,
        S_X_SAMPLE,
        S_Y_SETTLE,
        S_Y_SAMPLE,
        S_CHK_SETTLE,
        S_CHK_SAMPLE,
        S_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADC_W-1:0]  x_res_q, x_res_d;
    logic [ADC_W-1:0]  y_res_q, y_res_d;
    logic [ADC_W-1:0]  x_out_q, x_out_d;
    logic [ADC_W-1:0]  y_out_q, y_out_d;
    logic              pen_q, pen_d;
    logic              gap_q, gap_d;

    logic [ACC_W-1:0]  acc_sum;
    logic              captured;
    logic              pen_hit;
    logic              settle_done;
    logic              last_smp;

    function automatic logic is_settle(input state_t s);
        return s inside {S_PEN_SETTLE, S_X_SETTLE, S_Y_SETTLE, S_CHK_SETTLE};
    endfunction

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RST) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            scnt_q   <= '0;
            acc_q    <= '0;
            x_res_q  <= '0;
            y_res_q  <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            pen_q    <= 1'b0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            scnt_q   <= scnt_d;
            acc_q    <= acc_d;
            x_res_q  <= x_res_d;
            y_res_q  <= y_res_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            pen_q    <= pen_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        scnt_d      = scnt_q;
        acc_d       = acc_q;
        x_res_d     = x_res_q;
        y_res_d     = y_res_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        pen_d       = pen_q;
        gap_d       = 1'b0;
        acc_sum     = acc_q + ACC_W'(SAMPLE_DATA);
        captured    = SAMPLE_REQ && SAMPLE_ACK;
        pen_hit     = SAMPLE_DATA > PEN_THRESH;
        settle_done = (settle_q == '0);
        last_smp    = (scnt_q == LAST_SMP);

        if (!ENABLE) begin
            state_d = S_IDLE;
        end else begin
            // forces REQ low for one cycle after every accepted conversion
            gap_d = captured;
            case (state_q)
                S_IDLE: state_d = S_PEN_SETTLE;
                S_PEN_SETTLE: begin
                    settle_d = settle_q - CNT_W'(1);
                    if (settle_done) state_d = S_PEN_SAMPLE;
                end
                S_PEN_SAMPLE: begin
                    if (captured) begin
                        pen_d   = pen_hit;
                        state_d = pen_hit ? S_X_SETTLE : S_PEN_SETTLE;
                    end
                end
                S_X_SETTLE: begin
                    settle_d = settle_q - CNT_W'(1);
                    if (settle_done) state_d = S_X_SAMPLE;
                end
                S_Y_SETTLE: begin
                    settle_d = settle_q - CNT_W'(1);
                    if (settle_done) state_d = S_Y_SAMPLE;
                end
                S_X_SAMPLE, S_Y_SAMPLE: begin
                    if (captured) begin
                        acc_d  = acc_sum;
                        scnt_d = scnt_q + SCNT_W'(1);
                        if (last_smp) begin
                            if (state_q == S_X_SAMPLE) begin
                                x_res_d = ADC_W'(acc_sum >> AVG_LOG2);
                                state_d = S_Y_SETTLE;
                            end else begin
                                y_res_d = ADC_W'(acc_sum >> AVG_LOG2);
                                state_d = S_CHK_SETTLE;
                            end
                        end
                    end
                end
                S_CHK_SETTLE: begin
                    settle_d = settle_q - CNT_W'(1);
                    if (settle_done) state_d = S_CHK_SAMPLE;
                end
                S_CHK_SAMPLE: begin
                    if (captured) begin
                        if (pen_hit) begin
                            x_out_d = x_res_q;
                            y_out_d = y_res_q;
                            state_d = S_REPORT;
                        end else begin
                            pen_d   = 1'b0;
                            state_d = S_PEN_SETTLE;
                        end
                    end
                end
                S_REPORT: state_d = S_PEN_SETTLE;
                default:  state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q && is_settle(state_d)) settle_d = SETTLE_LOAD;
        if (state_d != S_X_SAMPLE && state_d != S_Y_SAMPLE) begin
            acc_d  = '0;
            scnt_d = '0;
        end
    end

    always_comb begin
        DRIVE_EN   = 4'b0000;
        DRIVE_VAL  = 4'b0000;
        SAMPLE_CH  = 1'b0;
        SAMPLE_REQ = 1'b0;
        XY_VALID   = 1'b0;
        case (state_q)
            S_PEN_SETTLE, S_PEN_SAMPLE, S_CHK_SETTLE, S_CHK_SAMPLE, S_REPORT: begin
                DRIVE_EN  = 4'b1001;
                DRIVE_VAL = 4'b1000;
                SAMPLE_CH = 1'b1;
            end
            S_X_SETTLE, S_X_SAMPLE: begin
                DRIVE_EN  = 4'b1100;
                DRIVE_VAL = 4'b1000;
                SAMPLE_CH = 1'b1;
            end
            S_Y_SETTLE, S_Y_SAMPLE: begin
                DRIVE_EN  = 4'b0011;
                DRIVE_VAL = 4'b0010;
                SAMPLE_CH = 1'b0;
            end
            default: ;
        endcase
        SAMPLE_REQ = (state_q inside {S_PEN_SAMPLE, S_X_SAMPLE, S_Y_SAMPLE, S_CHK_SAMPLE}) && !gap_q;
        XY_VALID   = (state_q == S_REPORT);
    end

    assign X_OUT    = x_out_q;
    assign Y_OUT    = y_out_q;
    assign PEN_DOWN = pen_q;

endmodule

// File: tb/tb_touch_scan_sequencer.sv
// Bench for touch_scan_sequencer: a procedural timeline model of the scan is compared
// against the DUT every cycle, plus directed literal checks on the reported coordinates.
module tb_touch_scan_sequencer;

    localparam int ADC_W    = 12;
    localparam int AVG_LOG2 = 2;
    localparam int SETTLE   = 4;
    localparam int NSMP     = 1 << AVG_LOG2;
    localparam logic [11:0] THRESH = 12'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        ack = 1'b0;
    logic [11:0] data = 12'h000;

    logic [3:0]  DRIVE_EN, DRIVE_VAL;
    logic        SAMPLE_REQ, SAMPLE_CH, XY_VALID, PEN_DOWN;
    logic [11:0] X_OUT, Y_OUT;

    touch_scan_sequencer #(
        .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .SETTLE_CYCLES(SETTLE), .PEN_THRESH(THRESH)
    ) dut (
        .FAB_CLK(clk), .FAB_RST(rst), .ENABLE(en),
        .DRIVE_EN(DRIVE_EN), .DRIVE_VAL(DRIVE_VAL),
        .SAMPLE_REQ(SAMPLE_REQ), .SAMPLE_CH(SAMPLE_CH),
        .SAMPLE_ACK(ack), .SAMPLE_DATA(data),
        .X_OUT(X_OUT), .Y_OUT(Y_OUT), .XY_VALID(XY_VALID), .PEN_DOWN(PEN_DOWN)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model: expected outputs after each clock edge ----------------
    logic [3:0]  m_en, m_val;
    logic        m_req, m_ch, m_valid, m_pen;
    logic [11:0] m_x, m_y;
    logic        e_rst, e_en, e_ack;
    logic [11:0] e_data;

    task automatic set_cfg(input int c);
        case (c)
            1:       begin m_en = 4'b1001; m_val = 4'b1000; m_ch = 1'b1; end
            2:       begin m_en = 4'b1100; m_val = 4'b1000; m_ch = 1'b1; end
            3:       begin m_en = 4'b0011; m_val = 4'b0010; m_ch = 1'b0; end
            default: begin m_en = 4'b0000; m_val = 4'b0000; m_ch = 1'b0; end
        endcase
        m_req   = 1'b0;
        m_valid = 1'b0;
    endtask

    // ab: 0 = normal edge, 1 = ENABLE low (abort, keep results), 2 = reset
    task automatic tick(output int ab);
        @(posedge clk);
        e_rst = rst; e_en = en; e_ack = ack; e_data = data;
        ab = 0;
        if (e_rst) begin
            ab = 2; m_x = '0; m_y = '0; m_pen = 1'b0; set_cfg(0);
        end else if (!e_en) begin
            ab = 1; set_cfg(0);
        end
    endtask

    task automatic settle(input int c, output int ab);
        set_cfg(c);
        ab = 0;
        repeat (SETTLE) begin
            tick(ab);
            if (ab != 0) return;
        end
    endtask

    task automatic take(output logic [11:0] v, output int ab);
        v = '0;
        m_req = 1'b1;
        forever begin
            tick(ab);
            if (ab != 0) return;
            if (e_ack) begin
                v = e_data;
                m_req = 1'b0;
                return;
            end
        end
    endtask

    task automatic axis(input int c, output logic [11:0] avg, output int ab);
        int unsigned sum;
        logic [11:0] v;
        sum = 0;
        avg = '0;
        settle(c, ab);
        if (ab != 0) return;
        for (int i = 0; i < NSMP; i++) begin
            take(v, ab);
            if (ab != 0) return;
            sum += v;
            if (i < NSMP - 1) begin
                tick(ab);
                if (ab != 0) return;
            end
        end
        avg = 12'(sum / NSMP);
    endtask

    task automatic scan(output int ab);
        logic [11:0] v, xr, yr;
        forever begin
            settle(1, ab);     if (ab != 0) return;
            take(v, ab);       if (ab != 0) return;
            m_pen = (v > THRESH);
            if (!m_pen) continue;
            axis(2, xr, ab);   if (ab != 0) return;
            axis(3, yr, ab);   if (ab != 0) return;
            settle(1, ab);     if (ab != 0) return;
            take(v, ab);       if (ab != 0) return;
            if (v <= THRESH) begin
                m_pen = 1'b0;
                continue;
            end
            m_x = xr; m_y = yr;
            set_cfg(1);
            m_valid = 1'b1;
            tick(ab);          if (ab != 0) return;
            m_valid = 1'b0;
        end
    endtask

    initial begin : model
        int ab;
        m_x = '0; m_y = '0; m_pen = 1'b0;
        set_cfg(0);
        forever begin
            tick(ab);
            if (ab == 0) scan(ab);
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("drive_en",   32'(DRIVE_EN),   32'(m_en));
            check("drive_val",  32'(DRIVE_VAL),  32'(m_val));
            check("sample_req", 32'(SAMPLE_REQ), 32'(m_req));
            if (m_req) check("sample_ch", 32'(SAMPLE_CH), 32'(m_ch));
            check("x_out",      32'(X_OUT),      32'(m_x));
            check("y_out",      32'(Y_OUT),      32'(m_y));
            check("xy_valid",   32'(XY_VALID),   32'(m_valid));
            check("pen_down",   32'(PEN_DOWN),   32'(m_pen));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (SAMPLE_REQ !== 1'b1) begin
            step();
            n++;
            if (n > 2000) begin
                n_checks++;
                $display("FAIL req_timeout: SAMPLE_REQ still %b after %0d cycles, required 1", SAMPLE_REQ, n);
                return;
            end
        end
    endtask

    task automatic serve(input logic [11:0] d, input int dly);
        wait_req();
        repeat (dly) step();
        ack = 1'b1;
        data = d;
        step();
        ack = 1'b0;
        data = 12'h5A5;
    endtask

    task automatic serve4(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d);
        serve(a, 0); serve(b, 1); serve(c, 0); serve(d, 2);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // 1: reset with ENABLE high
        rst = 1'b1; en = 1'b1; ack = 1'b0; data = '0;
        step(); step();
        check("rst_drive_en", 32'(DRIVE_EN),   32'h0);
        check("rst_req",      32'(SAMPLE_REQ), 32'h0);
        check("rst_x_out",    32'(X_OUT),      32'h0);
        check("rst_pen",      32'(PEN_DOWN),   32'h0);
        rst = 1'b0;
        step();
        check("pen_cfg_en",  32'(DRIVE_EN),  32'h9);
        check("pen_cfg_val", 32'(DRIVE_VAL), 32'h8);

        // 2: full touch scan
        serve(12'h200, 0);
        serve4(12'd100, 12'd102, 12'd104, 12'd106);
        serve4(12'd200, 12'd200, 12'd200, 12'd201);
        serve(12'h300, 0);
        check("t2_valid",   32'(XY_VALID), 32'h1);
        check("t2_x",       32'(X_OUT),    32'd103);
        check("t2_y",       32'(Y_OUT),    32'd200);
        check("t2_pen",     32'(PEN_DOWN), 32'h1);
        check("t2_model_x", 32'(m_x),      32'd103);
        step();
        check("t2_valid_end", 32'(XY_VALID), 32'h0);

        // 3: pen not down (below and exactly at threshold)
        serve(12'h050, 0);
        check("t3_pen_lo", 32'(PEN_DOWN), 32'h0);
        serve(12'h100, 0);
        check("t3_pen_eq", 32'(PEN_DOWN), 32'h0);
        repeat (3) step();
        check("t3_req_settle", 32'(SAMPLE_REQ), 32'h0);
        check("t3_cfg",        32'(DRIVE_EN),   32'h9);
        step();
        check("t3_req_again", 32'(SAMPLE_REQ), 32'h1);

        // 4: pen lifted during the final check
        serve(12'h300, 0);
        serve4(12'd10, 12'd20, 12'd30, 12'd40);
        serve4(12'd7, 12'd7, 12'd7, 12'd7);
        serve(12'h010, 0);
        check("t4_pen",   32'(PEN_DOWN), 32'h0);
        check("t4_x",     32'(X_OUT),    32'd103);
        check("t4_y",     32'(Y_OUT),    32'd200);
        check("t4_valid", 32'(XY_VALID), 32'h0);

        // 5: ENABLE drop mid X handshake, late ACK ignored
        serve(12'h200, 0);
        serve(12'd500, 0);
        wait_req();
        en = 1'b0;
        step();
        check("t5_drive_off", 32'(DRIVE_EN),   32'h0);
        check("t5_req_off",   32'(SAMPLE_REQ), 32'h0);
        step(); step();
        ack = 1'b1; data = 12'h7FF;
        step();
        ack = 1'b0;
        check("t5_x_hold",   32'(X_OUT),    32'd103);
        check("t5_pen_hold", 32'(PEN_DOWN), 32'h1);
        check("t5_req_idle", 32'(SAMPLE_REQ), 32'h0);
        en = 1'b1;
        step();
        check("t5_restart", 32'(DRIVE_EN), 32'h9);

        // 6: long ACK delay, stray ACK in the gap, full-scale X
        serve(12'h200, 0);
        serve(12'hFFF, 50);
        ack = 1'b1; data = 12'h000;
        step();
        ack = 1'b0;
        serve(12'hFFF, 0); serve(12'hFFF, 0); serve(12'hFFF, 0);
        serve4(12'h000, 12'h000, 12'h000, 12'h000);
        serve(12'h300, 0);
        check("t6_valid", 32'(XY_VALID), 32'h1);
        check("t6_x",     32'(X_OUT),    32'hFFF);
        check("t6_y",     32'(Y_OUT),    32'h000);

        // reset in the middle of a scan
        serve(12'h200, 0);
        step();
        rst = 1'b1;
        step();
        check("rst_mid_x",   32'(X_OUT),    32'h0);
        check("rst_mid_pen", 32'(PEN_DOWN), 32'h0);
        check("rst_mid_drv", 32'(DRIVE_EN), 32'h0);
        rst = 1'b0; en = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/touch_scan_sequencer.md
Name: touch_scan_sequencer

Overview:
- Fabric-side stage that feeds the touchscreen MSS subsystem.
- Sequences the 4-wire resistive panel electrodes and requests ADC conversions on the two direct ADC inputs through a request/acknowledge handshake.
- Averages the returned samples and presents a filtered X/Y coordinate and a pen-down flag for firmware to read over the fabric interface.

Parameters:
- ADC_W, 12, ADC sample and coordinate width.
- AVG_LOG2, 2, log2 of samples averaged per axis (2 gives 4 samples).
- SETTLE_CYCLES, 1000, clock cycles to wait after each electrode reconfiguration before sampling; must be >= 1.
- PEN_THRESH, 12'h100, pen-detect sample strictly above this means touch.

Ports:
- FAB_CLK  in  1  fabric clock; the single clock.
- FAB_RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  scanning enabled.
- DRIVE_EN  out  4  electrode drive enables {XP,XM,YP,YM}; 0 means tri-state.
- DRIVE_VAL  out  4  electrode drive levels {XP,XM,YP,YM}.
- SAMPLE_REQ  out  1  conversion request.
- SAMPLE_CH  out  1  channel select: 0 = ADCDirectInput_0 (X plate), 1 = ADCDirectInput_1 (Y plate).
- SAMPLE_ACK  in  1  conversion done; data valid this cycle.
- SAMPLE_DATA  in  ADC_W  conversion result.
- X_OUT  out  ADC_W  averaged X coordinate.
- Y_OUT  out  ADC_W  averaged Y coordinate.
- XY_VALID  out  1  one-cycle pulse when X_OUT/Y_OUT update.
- PEN_DOWN  out  1  last pen-detect result.

Behaviour:
Interface fixed:
- One clock; reset is synchronous and active-high.
- Clock port is FAB_CLK; reset port is FAB_RST.

Reset values:
- All outputs are 0.
- State is IDLE; settle counter, sample counter and accumulator are cleared.

Electrode configurations (DRIVE_EN / DRIVE_VAL):
- PEN: EN=1001, VAL=1000; sample CH=1.
- XM (X measure): EN=1100, VAL=1000; sample CH=1.
- YM (Y measure): EN=0011, VAL=0010; sample CH=0.
- IDLE: EN=0000, VAL=0000.

States:
- IDLE: drives off. If ENABLE=1, go to PEN_SETTLE next cycle.
- PEN_SETTLE, X_SETTLE, Y_SETTLE, CHK_SETTLE:
  - Apply the configuration on the entry cycle.
  - Count SETTLE_CYCLES cycles, then go to the matching _SAMPLE state.
- PEN_SAMPLE, X_SAMPLE, Y_SAMPLE, CHK_SAMPLE: run one handshake per sample.
- PEN_SAMPLE outcome:
  - If data > PEN_THRESH: set PEN_DOWN=1 and go to X_SETTLE.
  - Otherwise: set PEN_DOWN=0 and return to PEN_SETTLE (continuous polling, no report).
- X_SAMPLE / Y_SAMPLE:
  - Collect 2^AVG_LOG2 samples into an (ADC_W+AVG_LOG2)-bit accumulator.
  - Stored result = accumulator >> AVG_LOG2 (truncating).
  - X_SAMPLE goes to Y_SETTLE; Y_SAMPLE goes to CHK_SETTLE.
  - Accumulator and sample counter clear on entry to each axis.
- CHK_SAMPLE (uses PEN configuration):
  - If data > PEN_THRESH: go to REPORT.
  - Otherwise: set PEN_DOWN=0, discard both axis results, go to PEN_SETTLE. X_OUT/Y_OUT keep their old values.
- REPORT:
  - X_OUT/Y_OUT load the averaged results and XY_VALID=1 for exactly this cycle.
  - Next state is PEN_SETTLE.

Handshake:
- SAMPLE_REQ rises on the first cycle of a _SAMPLE state and stays high, with SAMPLE_CH stable, until a cycle where SAMPLE_ACK=1.
- SAMPLE_DATA is captured on that cycle; SAMPLE_REQ is 0 on the next cycle for at least one cycle before the next request.
- SAMPLE_ACK while SAMPLE_REQ=0 is ignored.
- There is no timeout; REQ is held indefinitely.

ENABLE deassertion (any state):
- On the next edge: go to IDLE, drives off, SAMPLE_REQ=0.
- Accumulators are discarded. X_OUT, Y_OUT and PEN_DOWN hold their values; XY_VALID=0.
- An ACK arriving after the abort is ignored.

FAB_RST:
- Overrides everything on any cycle, including mid-handshake and mid-settle.

Arithmetic:
- The accumulator must not overflow: maximum value is (2^ADC_W - 1) * 2^AVG_LOG2.
- The threshold compare is unsigned.

Test Plan:
1. Assert FAB_RST for 2 cycles with ENABLE=1 -> all outputs 0, state IDLE; after release, DRIVE_EN=1001 and DRIVE_VAL=1000 on the next cycle.
2. SETTLE_CYCLES=4, AVG_LOG2=2; pen sample 0x200; X samples 100,102,104,106; Y samples 200,200,200,201; check sample 0x300 -> one XY_VALID pulse with X_OUT=103, Y_OUT=200, PEN_DOWN=1.
3. Pen sample 0x050 (also exactly 0x100) -> PEN_DOWN=0, no XY_VALID, PEN configuration re-entered and REQ reissued after 4 settle cycles.
4. Full touch scan, but check sample 0x010 -> no XY_VALID, X_OUT/Y_OUT keep the previous report's values, PEN_DOWN=0.
5. Drop ENABLE while SAMPLE_REQ=1 in X_SAMPLE, then assert SAMPLE_ACK 3 cycles later -> next cycle DRIVE_EN=0000 and SAMPLE_REQ=0; ACK ignored; outputs held; re-enable restarts at PEN_SETTLE.
6. Delay SAMPLE_ACK 50 cycles and pulse a stray ACK while REQ=0 -> REQ held with CH stable for 50 cycles; stray ACK does not advance the sample count; all X samples 0xFFF -> X_OUT=0xFFF (no overflow).
